// File: rtl/crop_pkg.sv
// Shared types and default geometry for the crop stream transmitter.
package crop_pkg;

  localparam int unsigned FP_TOTAL_DEF = 16;
  localparam int unsigned IN_ROWS_DEF  = 100;
  localparam int unsigned IN_COLS_DEF  = 160;
  localparam int unsigned OUT_ROWS_DEF = 48;
  localparam int unsigned OUT_COLS_DEF = 48;
  localparam int unsigned Y_1_DEF      = 10;
  localparam int unsigned X_1_DEF      = 10;

  typedef logic [FP_TOTAL_DEF-1:0] pix_t;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} crop_state_t;

endpackage

// File: rtl/crop_win_counter.sv
// Raster row/column counters with crop-window and end-of-frame flags.
// Optional CROP_TLAST_EN adds the last-window-pixel flag.
module crop_win_counter
  import crop_pkg::*;
#(
  parameter int unsigned IN_ROWS  = IN_ROWS_DEF,
  parameter int unsigned IN_COLS  = IN_COLS_DEF,
  parameter int unsigned OUT_ROWS = OUT_ROWS_DEF,
  parameter int unsigned OUT_COLS = OUT_COLS_DEF,
  parameter int unsigned Y_1      = Y_1_DEF,
  parameter int unsigned X_1      = X_1_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic inwin,
  output logic last_pix
`ifdef CROP_TLAST_EN
  , output logic last_win
`endif
);

  localparam int unsigned RW = $clog2(IN_ROWS);
  localparam int unsigned CW = $clog2(IN_COLS);

  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic          c_end, r_end;

  always_comb begin
    c_end = (32'(c_q) == IN_COLS - 1);
    r_end = (32'(r_q) == IN_ROWS - 1);
    r_d   = r_q;
    c_d   = c_q;
    if (clr) begin
      r_d = '0;
      c_d = '0;
    end else if (adv) begin
      if (c_end) begin
        c_d = '0;
        r_d = r_end ? '0 : r_q + RW'(1);
      end else begin
        c_d = c_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  // Compare in 32 bits: the window end can equal IN_ROWS/IN_COLS, which may not fit the counters
  assign inwin = (32'(r_q) >= Y_1) && (32'(r_q) < Y_1 + OUT_ROWS) &&
                 (32'(c_q) >= X_1) && (32'(c_q) < X_1 + OUT_COLS);
  assign last_pix = r_end && c_end;
`ifdef CROP_TLAST_EN
  assign last_win = (32'(r_q) == Y_1 + OUT_ROWS - 1) && (32'(c_q) == X_1 + OUT_COLS - 1);
`endif

endmodule

// File: rtl/crop_stream_tx.sv
// AXI-stream crop transmitter: forwards a fixed window of a raster frame.
// Define CROP_TLAST_EN to add out_TLAST on the final window beat.
module crop_stream_tx
  import crop_pkg::*;
#(
  parameter int unsigned FP_TOTAL = FP_TOTAL_DEF,
  parameter int unsigned IN_ROWS  = IN_ROWS_DEF,
  parameter int unsigned IN_COLS  = IN_COLS_DEF,
  parameter int unsigned OUT_ROWS = OUT_ROWS_DEF,
  parameter int unsigned OUT_COLS = OUT_COLS_DEF,
  parameter int unsigned Y_1      = Y_1_DEF,
  parameter int unsigned X_1      = X_1_DEF
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  input  logic [FP_TOTAL-1:0] in_TDATA,
  input  logic                in_TVALID,
  output logic                in_TREADY,
  output logic [FP_TOTAL-1:0] out_TDATA,
  output logic                out_TVALID,
  input  logic                out_TREADY
`ifdef CROP_TLAST_EN
  , output logic              out_TLAST
`endif
);

  if ((Y_1 + OUT_ROWS > IN_ROWS) || (X_1 + OUT_COLS > IN_COLS)) begin : g_geom_err
    $error("crop_stream_tx: crop window exceeds input frame");
  end

  crop_state_t         state_q, state_d;
  logic [FP_TOTAL-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                idle_q, idle_d;
  logic                inwin, last_pix, clr, in_hs, out_hs, load;
`ifdef CROP_TLAST_EN
  logic                last_win, tlast_q, tlast_d;
`endif

  crop_win_counter #(
    .IN_ROWS (IN_ROWS),
    .IN_COLS (IN_COLS),
    .OUT_ROWS(OUT_ROWS),
    .OUT_COLS(OUT_COLS),
    .Y_1     (Y_1),
    .X_1     (X_1)
  ) u_cnt (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .clr     (clr),
    .adv     (in_hs),
    .inwin   (inwin),
    .last_pix(last_pix)
`ifdef CROP_TLAST_EN
    , .last_win(last_win)
`endif
  );

  always_comb begin
    // Out-of-window pixels are dropped, so only window pixels see backpressure
    in_TREADY = (state_q == STREAM) && (!inwin || !valid_q || out_TREADY);
    in_hs     = in_TVALID && in_TREADY;
    out_hs    = valid_q && out_TREADY;
    load      = in_hs && inwin;
    clr       = (state_q == IDLE) && ap_start;

    valid_d = load || (valid_q && !out_TREADY);
    data_d  = load ? in_TDATA : data_q;
`ifdef CROP_TLAST_EN
    tlast_d = load ? last_win : tlast_q;
`endif

    state_d = state_q;
    unique case (state_q)
      IDLE:   if (ap_start) state_d = STREAM;
      STREAM: if (in_hs && last_pix) state_d = DRAIN;
      DRAIN:  if (!valid_q || out_hs) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
`ifdef CROP_TLAST_EN
      tlast_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
`ifdef CROP_TLAST_EN
      tlast_q <= tlast_d;
`endif
    end
  end

  assign out_TDATA  = data_q;
  assign out_TVALID = valid_q;
  assign ap_done    = done_q;
  assign ap_idle    = idle_q;
`ifdef CROP_TLAST_EN
  assign out_TLAST  = tlast_q;
`endif

endmodule

// File: doc/crop_stream_tx.md
Name: crop_stream_tx

Overview:
- AXI-stream transmitter feeding the network's `conv2d_input` port with a cropped image.
- Accepts a full raster-order frame (`IN_ROWS` x `IN_COLS` pixels, one pixel per beat) and forwards only the `OUT_ROWS` x `OUT_COLS` window whose top-left corner is at (`Y_1`, `X_1`).
- Pixels outside the window are accepted and discarded.
- Sits between the frame source and the `myproject` top; uses an `ap_start`/`ap_done`/`ap_idle` control handshake.

Parameters:
- `FP_TOTAL`, 16, pixel word width in bits.
- `IN_ROWS`, 100, input frame rows.
- `IN_COLS`, 160, input frame columns.
- `OUT_ROWS`, 48, crop window rows.
- `OUT_COLS`, 48, crop window columns.
- `Y_1`, 10, first row of the window (0-based).
- `X_1`, 10, first column of the window (0-based).

Ports:
- `ap_clk`  in  1  clock; all logic on the rising edge.
- `ap_rst`  in  1  asynchronous, active-high reset.
- `ap_start`  in  1  one-cycle request to process one frame.
- `ap_done`  out  1  one-cycle pulse when the frame has completed.
- `ap_idle`  out  1  high while in IDLE.
- `in_TDATA`  in  `FP_TOTAL`  input pixel.
- `in_TVALID`  in  1  input pixel valid.
- `in_TREADY`  out  1  block can accept an input pixel.
- `out_TDATA`  out  `FP_TOTAL`  cropped pixel to the network.
- `out_TVALID`  out  1  output pixel valid.
- `out_TREADY`  in  1  network ready.

Behaviour:
- Reset values: state=IDLE, `ap_done`=0, `ap_idle`=1, `in_TREADY`=0, `out_TVALID`=0, `out_TDATA`=0, row/col counters=0. Reset is asynchronous and may assert mid-frame; everything returns to these values immediately and any partial frame is lost.
- Elaboration check: `Y_1`+`OUT_ROWS` <= `IN_ROWS` and `X_1`+`OUT_COLS` <= `IN_COLS`, otherwise `$error`.
- Counters:
  - row counter `r` is `$clog2(IN_ROWS)` bits; column counter `c` is `$clog2(IN_COLS)` bits.
  - They advance only on an input handshake (`in_TVALID` & `in_TREADY`).
  - `c` wraps to 0 at `IN_COLS`-1 and `r` then increments.
- Window test: `inwin` = (`r` >= `Y_1`) & (`r` < `Y_1`+`OUT_ROWS`) & (`c` >= `X_1`) & (`c` < `X_1`+`OUT_COLS`), evaluated on the current counter values.
- Output register: a single entry (`out_TDATA`/`out_TVALID`).
  - A window pixel handshaked at edge N is visible on `out_TDATA` after edge N (latency 1).
  - `out_TVALID` clears on an output handshake unless it is reloaded in the same cycle.
- `in_TREADY` = (state==STREAM) & (!`inwin` | !`out_TVALID` | `out_TREADY`).
  - Out-of-window pixels are never stalled by output backpressure.
- `out_TDATA` is stable while `out_TVALID` & !`out_TREADY` (AXI-stream rule).
- FSM:
  - IDLE: `ap_idle`=1. `ap_start` -> STREAM; counters cleared.
  - STREAM: accept pixels. Handshake on (`r`,`c`) = (`IN_ROWS`-1, `IN_COLS`-1) -> DRAIN.
  - DRAIN: `in_TREADY`=0. When `out_TVALID`=0, or an output handshake occurs this cycle -> DONE.
  - DONE: `ap_done`=1 for exactly one cycle -> IDLE.
- `ap_start` outside IDLE is ignored. `ap_start` held high in IDLE starts exactly one frame per IDLE visit.
- Exactly `OUT_ROWS`*`OUT_COLS` output beats are produced per frame.

Optional Feature:
- Macro `CROP_TLAST_EN`.
- Defined: adds output port `out_TLAST` (1 bit, reset 0). It is registered alongside `out_TDATA` and high only on the beat for window position (`OUT_ROWS`-1, `OUT_COLS`-1).
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Package `crop_pkg`:
  - pixel typedef `pix_t` (`logic [FP_TOTAL-1:0]`, default 16);
  - enum `crop_state_t` {IDLE, STREAM, DRAIN, DONE};
  - default geometry localparams.
- Sub-module `crop_win_counter`: row/column counters plus the `inwin`/last-pixel flags, instantiated once. The FSM and output register stay in the top.

Test Plan (params 8x10 -> 4x4, `Y_1`=2, `X_1`=3; input pixel value = `r`*10+`c`):
- `ap_start` pulse, `in_TVALID`=1, `out_TREADY`=1 constant -> outputs in order 23,24,25,26,33,...,56; 16 beats; `ap_done` 1 cycle after the last beat; `ap_idle`=1 afterward.
- Random 50% `in_TVALID` and `out_TREADY` -> same 16-value sequence. `out_TDATA` is never changed while stalled, and `in_TREADY`=1 during stalls whenever (`r`,`c`) is outside the window.
- `out_TREADY`=0 held after pixel 23 is captured -> `in_TREADY` drops on pixel 24 but stays high for pixels 0..22-equivalent out-of-window positions; releasing `out_TREADY` resumes with 24.
- Assert `ap_rst` for 1 cycle after 40 input beats -> all outputs at reset values. A new `ap_start` plus full frame yields 23..56 again with no stale beat.
- `ap_start` pulsed during STREAM -> ignored; exactly 16 outputs and one `ap_done`.
- With `CROP_TLAST_EN`: `out_TLAST`=1 only on value 56. Run two back-to-back frames -> TLAST seen twice and `ap_done` pulses twice.
